// File: rtl/mem_access_if.sv
// ---------------------------------------------------------------------------
// mem_access_if
// Purpose: groups the request handshake from the control FSM, the unified
//          instruction/data memory bus and the IR/MDR result registers used by
//          mem_access_unit into one bundle.
// Parameters:
//   ADDR_W  memory word-address width
//   DATA_W  data/instruction width
// Signals:
//   req_valid, req_op, pc, alu_out, store_data  control -> unit request
//   req_ready                                    unit -> control, idle/accepting
//   mem_address, mem_write, mem_write_data       unit -> memory
//   mem_read_data                                memory -> unit (combinational)
//   ir, mdr                                      captured instruction / data
//   done, fault                                  one-cycle completion status
// Modports:
//   slave   the access unit
//   master  the surrounding datapath/control plus memory
// ---------------------------------------------------------------------------
interface mem_access_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [31:0]       pc;
  logic [31:0]       alu_out;
  logic [DATA_W-1:0] store_data;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_write;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mdr;
  logic              done;
  logic              fault;

  modport slave (
    input  req_valid, req_op, pc, alu_out, store_data, mem_read_data,
    output req_ready, mem_address, mem_write, mem_write_data, ir, mdr, done, fault
  );

  modport master (
    output req_valid, req_op, pc, alu_out, store_data, mem_read_data,
    input  req_ready, mem_address, mem_write, mem_write_data, ir, mdr, done, fault
  );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
// Purpose: sequences single accesses between the multi-cycle datapath/control
//          and the unified instruction/data memory. A fetch reads the word at
//          PC into IR, a load reads the word at ALUOut into MDR, a store
//          writes store_data at ALUOut. Completion is a one-cycle done pulse,
//          with fault set when the request was rejected.
// Parameters:
//   ADDR_W     memory word-address width (depth 2**ADDR_W words)
//   DATA_W     data/instruction width
//   READ_WAIT  cycles the address is held before read data is captured (1..3)
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      mem_access_if.slave: request handshake, memory bus, ir/mdr,
//            done/fault
// Build option:
//   ALIGN_CHECK_EN  when defined, misaligned addresses and addresses beyond
//                   the memory take the fault path; otherwise the low two bits
//                   are ignored and the address wraps modulo the memory size.
//                   req_op=11 faults in both builds.
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int READ_WAIT = 1
) (
  input logic         clk,
  input logic         reset_n,
  mem_access_if.slave bus
);

  localparam logic [1:0] OP_FETCH  = 2'b00;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;
  localparam logic [1:0] WAIT_INIT = 2'(READ_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [1:0]        r_op;
  logic              r_fault;
  logic [1:0]        r_waitCnt;
  logic [ADDR_W-1:0] r_memAddress;
  logic [DATA_W-1:0] r_memWriteData;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_mdr;

  logic              w_reqReady;
  logic              w_accept;
  logic [31:0]       w_reqAddr;
  logic [ADDR_W-1:0] w_wordAddr;
  logic              w_reqFault;

  // The unit only takes a request while idle and out of reset; fetches use
  // PC, everything else uses ALUOut as the byte address.
  assign w_reqReady = (r_state == S_IDLE) & reset_n;
  assign w_accept   = bus.req_valid & w_reqReady;
  assign w_reqAddr  = (bus.req_op == OP_FETCH) ? bus.pc : bus.alu_out;
  assign w_wordAddr = w_reqAddr[ADDR_W+1:2];

`ifdef ALIGN_CHECK_EN
  // Reject byte offsets and any address bit above the memory's reach.
  logic w_misaligned;
  logic w_outOfRange;
  assign w_misaligned = |w_reqAddr[1:0];
  assign w_outOfRange = |(w_reqAddr >> (ADDR_W + 2));
  assign w_reqFault   = (bus.req_op == OP_RSVD) | w_misaligned | w_outOfRange;
`else
  // Offset and upper bits are dropped so the address wraps around memory.
  logic w_unusedAddrBits;
  assign w_unusedAddrBits = ^{w_reqAddr[31:ADDR_W+2], w_reqAddr[1:0]};
  assign w_reqFault       = (bus.req_op == OP_RSVD);
`endif

  // Next-state logic: rejected requests go straight to DONE so control sees
  // the fault one cycle after acceptance; reads sit in WAIT until the
  // countdown expires; a store spends exactly one cycle in WRITE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_reqFault)                   w_nextState = S_DONE;
          else if (bus.req_op == OP_STORE)  w_nextState = S_WRITE;
          else                              w_nextState = S_WAIT;
        end
      end
      S_WAIT:  if (r_waitCnt == 2'd0) w_nextState = S_DONE;
      S_WRITE: w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // State register and datapath registers. Request fields are sampled only
  // on the accept edge; a faulting request leaves the memory address alone
  // since no access happens. The read capture lands on the edge where the
  // countdown is zero, and only the targeted register (IR or MDR) changes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_op           <= 2'b00;
      r_fault        <= 1'b0;
      r_waitCnt      <= 2'd0;
      r_memAddress   <= '0;
      r_memWriteData <= '0;
      r_ir           <= '0;
      r_mdr          <= '0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= bus.req_op;
            r_fault   <= w_reqFault;
            r_waitCnt <= WAIT_INIT;
            if (!w_reqFault) begin
              r_memAddress <= w_wordAddr;
              if (bus.req_op == OP_STORE) r_memWriteData <= bus.store_data;
            end
          end
        end
        S_WAIT: begin
          if (r_waitCnt == 2'd0) begin
            if (r_op == OP_FETCH) r_ir  <= bus.mem_read_data;
            else                  r_mdr <= bus.mem_read_data;
          end else begin
            r_waitCnt <= r_waitCnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Write enable and done are gated by reset_n so a reset arriving in the
  // WRITE or DONE cycle suppresses the write and the completion pulse.
  assign bus.req_ready      = w_reqReady;
  assign bus.mem_address    = r_memAddress;
  assign bus.mem_write      = (r_state == S_WRITE) & reset_n;
  assign bus.mem_write_data = r_memWriteData;
  assign bus.ir             = r_ir;
  assign bus.mdr            = r_mdr;
  assign bus.done           = (r_state == S_DONE) & reset_n;
  assign bus.fault          = (r_state == S_DONE) & reset_n & r_fault;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
// Self-checking bench for mem_access_unit. A memory array answers reads
// combinationally and takes writes on the clock edge. A reference model
// tracks, per cycle, when done/mem_write must appear and what IR/MDR and the
// memory must hold, and is compared against the unit every cycle. Directed
// sequences pin the model with hand-computed values; a randomized phase
// follows. Expectations follow ALIGN_CHECK_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 32;
  localparam int READ_WAIT = 1;
  localparam int DEPTH     = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  mem_access_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_WAIT(READ_WAIT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n = 0;

  function automatic logic [31:0] preloadWord(input int i);
    if (i == 0)      return 32'hac620000;
    else if (i == 1) return 32'h8c640000;
    else             return 32'h10000000 + 32'(i) * 32'h11;
  endfunction

  // Memory: combinational read, write on the rising edge when enabled.
  logic [31:0] envMem [DEPTH];
  assign bus.mem_read_data = envMem[bus.mem_address];

  always @(posedge clk) begin
    if (bus.mem_write) envMem[bus.mem_address] <= bus.mem_write_data;
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) envMem[i] <= preloadWord(i);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  // Reference model state: one access in flight, described by the cycles at
  // which its write and done must appear and what it will capture.
  bit          primed = 1'b0;
  bit          active = 1'b0;
  int          doneP, wrP, capT, wAddr;
  bit          fFlag;
  logic [31:0] capV, wData, refIr, refMdr;
  logic [31:0] refMem [DEPTH];
  bit          expDone, expWr, expReady;
  logic [31:0] acceptAddr;
  bit          acceptFault;
  int          acceptWord;

  // Compare process: every cycle, sampled at the falling edge.
  always @(negedge clk) begin
    n++;
    if (!primed) begin
      if (!reset_n) begin
        primed = 1'b1;
        active = 1'b0;
        refIr  = '0;
        refMdr = '0;
        for (int i = 0; i < DEPTH; i++) refMem[i] = preloadWord(i);
      end
    end else begin
      if (active && n == doneP && capT == 1) refIr  = capV;
      if (active && n == doneP && capT == 2) refMdr = capV;
      expDone  = reset_n && active && (n == doneP);
      expWr    = reset_n && active && (n == wrP);
      expReady = reset_n && !active;
      checkOutput("done",      32'(bus.done),      32'(expDone));
      checkOutput("fault",     32'(bus.fault),     32'(expDone && fFlag));
      checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));
      checkOutput("mem_write", 32'(bus.mem_write), 32'(expWr));
      checkOutput("ir",        bus.ir,             refIr);
      checkOutput("mdr",       bus.mdr,            refMdr);
      if (expWr) begin
        checkOutput("mem_address",    32'(bus.mem_address), 32'(wAddr));
        checkOutput("mem_write_data", bus.mem_write_data,   wData);
        refMem[wAddr] = wData;
      end
      if (active && n == doneP) active = 1'b0;
      if (!reset_n) begin
        active = 1'b0;
        refIr  = '0;
        refMdr = '0;
      end else if (expReady && bus.req_valid) begin
        acceptAddr  = (bus.req_op == 2'b00) ? bus.pc : bus.alu_out;
        acceptFault = (bus.req_op == 2'b11);
`ifdef ALIGN_CHECK_EN
        if ((acceptAddr % 4) != 0 || acceptAddr >= 32'(4 * DEPTH)) acceptFault = 1'b1;
`endif
        acceptWord = int'((acceptAddr / 4) % DEPTH);
        active = 1'b1;
        fFlag  = acceptFault;
        capT   = 0;
        wrP    = -1;
        if (acceptFault) begin
          doneP = n + 1;
        end else if (bus.req_op == 2'b10) begin
          wrP   = n + 1;
          doneP = n + 2;
          wAddr = acceptWord;
          wData = bus.store_data;
        end else begin
          doneP = n + READ_WAIT + 1;
          capT  = (bus.req_op == 2'b00) ? 1 : 2;
          capV  = refMem[acceptWord];
        end
      end
    end
  end

  function automatic logic [31:0] randomAddress();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 7)       return 32'($urandom_range(0, 15)) * 4;
    else if (sel == 7) return 32'($urandom_range(0, 63));
    else if (sel == 8) return $urandom;
    else               return 32'h100 + 32'($urandom_range(0, 15)) * 4;
  endfunction

  // Issue one request and follow it to done. With keepValid the request
  // line stays high and the fields are scrambled while busy. rstAt > 0
  // pulls reset low in that cycle after acceptance, aborting the access.
  task automatic applyStimulus(
    input  logic [1:0]        op,
    input  logic [31:0]       pcVal,
    input  logic [31:0]       aluVal,
    input  logic [DATA_W-1:0] dataVal,
    input  bit                keepValid,
    input  int                rstAt,
    output int                latency,
    output int                writeCycles,
    output bit                sawFault
  );
    int waitCnt;
    bit finished;
    latency = -1;
    writeCycles = 0;
    sawFault = 1'b0;
    finished = 1'b0;
    @(posedge clk); #1;
    bus.req_op = op;
    bus.pc = pcVal;
    bus.alu_out = aluVal;
    bus.store_data = dataVal;
    bus.req_valid = 1'b1;
    @(negedge clk);
    waitCnt = 0;
    while (!bus.req_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!bus.req_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: req_ready=%0b, required 1 within 20 cycles", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    for (int c = 1; c <= 12 && !finished; c++) begin
      @(posedge clk); #1;
      if (!keepValid) begin
        bus.req_valid = 1'b0;
      end else begin
        bus.req_op = 2'($urandom_range(0, 3));
        bus.pc = $urandom;
        bus.alu_out = $urandom;
        bus.store_data = $urandom;
      end
      if (c == rstAt) reset_n = 1'b0;
      @(negedge clk);
      if (bus.mem_write) writeCycles++;
      if (bus.done) begin
        latency = c;
        sawFault = bus.fault;
        finished = 1'b1;
      end else if (c == rstAt) begin
        finished = 1'b1;
        bus.req_valid = 1'b0;
      end
    end
    if (!reset_n) begin
      @(posedge clk); #1;
      reset_n = 1'b1;
    end
    if (!finished) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: done=%0b, required 1 within 12 cycles", bus.done);
    end
  endtask

  int          lat, wr;
  bit          flt;
  logic [1:0]  rOp;
  logic [31:0] rPc, rAlu, rSd;
  bit          rKeep;
  int          rRst;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = 2'b00;
    bus.pc = '0;
    bus.alu_out = '0;
    bus.store_data = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("reset_done",      32'(bus.done),      32'd0);
    checkOutput("reset_mem_write", 32'(bus.mem_write), 32'd0);
    checkOutput("reset_ir",        bus.ir,             32'h0);
    checkOutput("reset_mdr",       bus.mdr,            32'h0);

    // Fetches of the two preloaded words.
    applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 1'b0, -1, lat, wr, flt);
    checkOutput("t1_fetch0_latency", 32'(lat), 32'd2);
    checkOutput("t1_fetch0_fault",   32'(flt), 32'd0);
    checkOutput("t1_fetch0_ir",      bus.ir,   32'hac620000);
    applyStimulus(2'b00, 32'h4, 32'h0, 32'h0, 1'b0, -1, lat, wr, flt);
    checkOutput("t1_fetch4_ir",      bus.ir,   32'h8c640000);

    // Store then load back the same word.
    applyStimulus(2'b10, 32'h0, 32'h0C, 32'hDEADBEEF, 1'b0, -1, lat, wr, flt);
    checkOutput("t2_store_latency",  32'(lat), 32'd2);
    checkOutput("t2_store_writes",   32'(wr),  32'd1);
    checkOutput("t2_store_address",  32'(bus.mem_address), 32'd3);
    applyStimulus(2'b01, 32'h0, 32'h0C, 32'h0, 1'b0, -1, lat, wr, flt);
    checkOutput("t2_load_mdr",       bus.mdr,  32'hDEADBEEF);
    checkOutput("t2_load_ir_kept",   bus.ir,   32'h8c640000);

    // Misaligned and out-of-range loads.
    applyStimulus(2'b01, 32'h0, 32'h08, 32'h0, 1'b0, -1, lat, wr, flt);
    checkOutput("t3_load_word2_mdr", bus.mdr,  32'h10000022);
    applyStimulus(2'b01, 32'h0, 32'h0D, 32'h0, 1'b0, -1, lat, wr, flt);
`ifdef ALIGN_CHECK_EN
    checkOutput("t3_misaligned_latency", 32'(lat), 32'd1);
    checkOutput("t3_misaligned_fault",   32'(flt), 32'd1);
    checkOutput("t3_misaligned_writes",  32'(wr),  32'd0);
    checkOutput("t3_misaligned_mdr",     bus.mdr,  32'h10000022);
`else
    checkOutput("t3_misaligned_fault",   32'(flt), 32'd0);
    checkOutput("t3_misaligned_mdr",     bus.mdr,  32'hDEADBEEF);
`endif
    applyStimulus(2'b01, 32'h0, 32'h100, 32'h0, 1'b0, -1, lat, wr, flt);
`ifdef ALIGN_CHECK_EN
    checkOutput("t4_range_fault",        32'(flt), 32'd1);
    checkOutput("t4_range_mdr",          bus.mdr,  32'h10000022);
`else
    checkOutput("t4_wrap_fault",         32'(flt), 32'd0);
    checkOutput("t4_wrap_mdr",           bus.mdr,  32'hac620000);
`endif

    // Reset during the WRITE cycle of a store to word 5.
    applyStimulus(2'b10, 32'h0, 32'h14, 32'hCAFEF00D, 1'b0, 1, lat, wr, flt);
    checkOutput("t5_abort_writes", 32'(wr), 32'd0);
    @(negedge clk);
    checkOutput("t5_after_reset_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("t5_after_reset_done",  32'(bus.done),      32'd0);
    checkOutput("t5_after_reset_ir",    bus.ir,             32'h0);
    checkOutput("t5_after_reset_mdr",   bus.mdr,            32'h0);
    applyStimulus(2'b01, 32'h0, 32'h14, 32'h0, 1'b0, -1, lat, wr, flt);
    checkOutput("t5_word5_unchanged",   bus.mdr,            32'h10000055);

    // Reserved op, then back-to-back fetches with req_valid held high.
    applyStimulus(2'b11, 32'h0, 32'h0, 32'h0, 1'b0, -1, lat, wr, flt);
    checkOutput("t6_rsvd_latency", 32'(lat), 32'd1);
    checkOutput("t6_rsvd_fault",   32'(flt), 32'd1);
    checkOutput("t6_rsvd_writes",  32'(wr),  32'd0);
    checkOutput("t6_rsvd_ir",      bus.ir,   32'h0);
    checkOutput("t6_rsvd_mdr",     bus.mdr,  32'h10000055);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(2'b00, (k % 2 == 0) ? 32'h0 : 32'h4, 32'h0, 32'h0, 1'b1, -1, lat, wr, flt);
      checkOutput("t6_b2b_latency", 32'(lat), 32'd2);
      checkOutput("t6_b2b_ir", bus.ir, (k % 2 == 0) ? 32'hac620000 : 32'h8c640000);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;

    // Randomized phase against the reference model.
    for (int it = 0; it < 300; it++) begin
      rOp   = 2'($urandom_range(0, 3));
      rPc   = randomAddress();
      rAlu  = randomAddress();
      rSd   = $urandom;
      rKeep = ($urandom_range(0, 3) == 0);
      rRst  = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 3)) : -1;
      applyStimulus(rOp, rPc, rAlu, rSd, rKeep, rRst, lat, wr, flt);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound in case the run stalls.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
